apb_cmd_master: RTL
===================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of ACCESS cycles with PREADY low before the transfer is aborted; legal range is 1..255.
REQ-002 PCLK  input  1  is the single clock; all state updates on its rising edge.
REQ-003 PRESET  input  1  is the reset: synchronous and active-high, sampled on the rising edge of PCLK.
REQ-004 cmd_valid  input  1  means a command is offered.
REQ-005 cmd_ready  output  1  means a command can be accepted this cycle.
REQ-006 cmd_write  input  1  selects the command type: 1 = write, 0 = read.
REQ-007 cmd_addr  input  [11:2]  is the word address.
REQ-008 cmd_wdata  input  32  is the write data.
REQ-009 rsp_valid  output  1  means a response is presented.
REQ-010 rsp_ready  input  1  means the consumer accepts the response.
REQ-011 rsp_rdata  output  32  is the read data; it is 0 for writes, errors and timeouts.
REQ-012 rsp_err  output  1  flags a response error: PSLVERR was seen or the transfer timed out.
REQ-013 rsp_timeout  output  1  flags that the transfer was aborted by the timeout.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  are the APB control outputs.
REQ-015 PADDR  output  [11:2]  is the APB address.
REQ-016 PWDATA  output  32  is the APB write data.
REQ-017 PRDATA  input  32, PREADY  input  1, PSLVERR  input  1  are the APB completer response inputs.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP; the reset state is IDLE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 at a rising edge, and the FSM then moves to SETUP.
REQ-020 On acceptance, cmd_write, cmd_addr and cmd_wdata SHALL be registered; PWDATA carries cmd_wdata for writes and 0 for reads.
REQ-021 SETUP lasts exactly one cycle with PSEL=1 and PENABLE=0, then moves unconditionally to ACCESS.
REQ-022 In ACCESS, PSEL=1 and PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP until the transfer ends.
REQ-023 In ACCESS, PREADY=1 at a rising edge SHALL end the transfer and move the FSM to RESP, capturing rsp_err=PSLVERR, rsp_timeout=0, and rsp_rdata=PRDATA for a read with PSLVERR=0, otherwise 0.
REQ-024 An 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-025 If the wait counter reaches TIMEOUT_CYCLES with PREADY still 0, the FSM SHALL move to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-026 When PREADY=1 arrives on the same edge that the timeout is reached, PREADY SHALL win and the transfer completes normally.
REQ-027 Outside SETUP and ACCESS, PSEL, PENABLE, PWRITE, PADDR and PWDATA SHALL be 0.
REQ-028 In RESP, rsp_valid=1 and all rsp_* outputs SHALL hold stable until rsp_ready=1 at an edge; the FSM then returns to IDLE.
REQ-029 rsp_valid SHALL be 0 in every state except RESP.
REQ-030 Zero-wait latency: a command accepted at edge N gives PSEL=1 after N, PENABLE=1 after N+1 and rsp_valid=1 after N+2.
REQ-031 With rsp_ready tied high, back-to-back transfers SHALL take 4 cycles each.
REQ-032 PRDATA, PREADY and PSLVERR SHALL be ignored outside ACCESS.

Reset
REQ-033 PRESET=1 at a rising edge SHALL force IDLE and clear all outputs to 0 and the counter to 0, except cmd_ready, which becomes 1 once PRESET is low.
REQ-034 A reset asserted during SETUP, ACCESS or RESP SHALL drop PSEL and PENABLE at that same edge, discard the transfer and produce no response.
REQ-035 While PRESET=1, cmd_ready SHALL be 0.

Verification
REQ-036 Write with the completer giving PREADY=1 immediately, addr 0x000, data 0x9 -> PSEL rises at edge N, PENABLE at N+1, PWRITE=1, PWDATA=0x9, rsp_valid at N+2, rsp_err=0.
REQ-037 Read of addr 0x001 with 3 wait states and PRDATA=0x32 -> ACCESS lasts 4 cycles, rsp_rdata=0x32, rsp_err=0.
REQ-038 Write with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-039 TIMEOUT_CYCLES=4 with PREADY held 0 -> PSEL drops after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1; PREADY arriving on the 4th edge -> normal completion.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_* stay stable, cmd_ready stays 0, and a second command is accepted only after the response handshake.
REQ-041 PRESET pulsed during ACCESS -> PSEL=0 and cmd_ready=0 on the next cycle, then cmd_ready=1, and no rsp_valid pulse occurs.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_master_if                                                  |
// | Command/response handshake plus APB requester signals.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface apb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:2] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_master                                                     |
// | Turns one command into one APB transfer with a wait-state timeout. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input wire                PCLK,
  input wire                PRESET,
  apb_cmd_master_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_cmd_ready;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [11:2] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rsp_timeout;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= 8'd0;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= 32'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 32'd0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_state     <= ST_SETUP;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_pwrite    <= bus.cmd_write;
            r_paddr     <= bus.cmd_addr;
            r_pwdata    <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
          end
        end

        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          r_penable  <= 1'b1;
          r_wait_cnt <= 8'd0;
        end

        ST_ACCESS: begin
          // PREADY is checked first so a completion on the timeout edge wins
          if (bus.PREADY || (r_wait_cnt == c_WAIT_LAST)) begin
            r_state       <= ST_RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= 32'd0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= bus.PREADY ? bus.PSLVERR : 1'b1;
            r_rsp_timeout <= !bus.PREADY;
            r_rsp_rdata   <= (bus.PREADY && !r_pwrite && !bus.PSLVERR) ? bus.PRDATA : 32'd0;
          end
          if (!bus.PREADY) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;

endmodule
`default_nettype wire
